// File: rtl/fpga_cfg_readback.sv
// Serial readback of a parallel flop snapshot over a valid/ready bit link,
// with optional trailing even-parity beat and a global clock enable.
module fpga_cfg_readback #(
  parameter int WIDTH     = 32,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             E_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             sdo_o,
  output logic             sdo_valid_o,
  input  logic             sdo_ready_i,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int N  = WIDTH + PARITY_EN;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_PAR  = CW'(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             in_shift, par_beat, data_bit, hs;

  assign in_shift    = (state_q == S_SHIFT);
  assign par_beat    = (PARITY_EN != 0) && (cnt_q == CNT_PAR);
  assign data_bit    = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sdo_valid_o = in_shift & E_i;
  assign sdo_o       = in_shift & (par_beat ? par_q : data_bit);
  assign last_o      = sdo_valid_o & (cnt_q == CNT_LAST);
  assign hs          = sdo_valid_o & sdo_ready_i;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    // With E_i low nothing advances, mirroring the enable-gated storage flops.
    if (E_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
            par_d   = 1'b0;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (hs) begin
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
            if (!par_beat) par_d = par_q ^ data_bit;
            cnt_d = cnt_q + 1'b1;
            if (last_o) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end
endmodule

// File: tb/tb_fpga_cfg_readback.sv
// Directed bench for fpga_cfg_readback: three configurations share inputs,
// a frame table drives the plain cases, hand sequences cover the corners.
module tb_fpga_cfg_readback;
  logic       clk = 1'b0;
  logic       reset, e, start, ready;
  logic [7:0] data;
  logic [2:0] sdo, vld, last, busy, done;

  always #5 clk = ~clk;

  fpga_cfg_readback #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) u0 (
    .clk_i(clk), .reset_i(reset), .E_i(e), .start_i(start), .data_i(data),
    .sdo_o(sdo[0]), .sdo_valid_o(vld[0]), .sdo_ready_i(ready),
    .last_o(last[0]), .busy_o(busy[0]), .done_o(done[0]));
  fpga_cfg_readback #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u1 (
    .clk_i(clk), .reset_i(reset), .E_i(e), .start_i(start), .data_i(data),
    .sdo_o(sdo[1]), .sdo_valid_o(vld[1]), .sdo_ready_i(ready),
    .last_o(last[1]), .busy_o(busy[1]), .done_o(done[1]));
  fpga_cfg_readback #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u2 (
    .clk_i(clk), .reset_i(reset), .E_i(e), .start_i(start), .data_i(data),
    .sdo_o(sdo[2]), .sdo_valid_o(vld[2]), .sdo_ready_i(ready),
    .last_o(last[2]), .busy_o(busy[2]), .done_o(done[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; e = 1'b1; ready = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  // Capture, then nb beats with ready=1, then DONE and back to IDLE.
  task automatic run_frame(input int s, input logic [7:0] d, input logic [8:0] seq,
                           input int nb, input string tag);
    logic [8:0] q;
    int busy_cnt;
    q = seq;
    busy_cnt = 0;
    data = d; start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    for (int i = 0; i < nb; i++) begin
      chk({tag, "_valid"}, vld[s], 1'b1);
      chk({tag, "_sdo"},   sdo[s], q[i]);
      chk({tag, "_last"},  last[s], (i == nb - 1));
      if (busy[s]) busy_cnt++;
      cyc();
    end
    chk({tag, "_done"},       done[s], 1'b1);
    chk({tag, "_done_valid"}, vld[s], 1'b0);
    if (busy[s]) busy_cnt++;
    cyc();
    chk({tag, "_done_pulse"}, done[s], 1'b0);
    chk({tag, "_idle_busy"},  busy[s], 1'b0);
    chk({tag, "_busy_cycles"}, busy_cnt, nb + 1);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic [8:0] seq;   // bit i = expected sdo on beat i
    int         nb;
  } frame_t;

  frame_t tbl [6];

  initial begin
    logic [8:0] q;
    int b, hs, fr, last_hs;
    logic seen_done, prev_v;

    tbl[0] = '{0, 8'hA5, 9'h0A5, 9};
    tbl[1] = '{1, 8'h07, 9'h1E0, 9};
    tbl[2] = '{0, 8'h80, 9'h180, 9};
    tbl[3] = '{1, 8'h01, 9'h180, 9};
    tbl[4] = '{2, 8'hC3, 9'h0C3, 8};
    tbl[5] = '{1, 8'h6E, 9'h176, 9};

    data = 8'h00;
    do_reset();
    chk("reset_outputs", {17'd0, sdo, vld, last, busy, done}, 32'd0);

    foreach (tbl[t]) begin
      do_reset();
      run_frame(tbl[t].sel, tbl[t].d, tbl[t].seq, tbl[t].nb, $sformatf("tbl%0d", t));
    end

    // Backpressure with ready 1,0,0,... and data_i overwritten mid-frame.
    do_reset();
    q = 9'h03C;
    data = 8'h3C; start = 1'b1;
    cyc();
    start = 1'b0;
    b = 0; hs = 0; seen_done = 1'b0;
    for (int k = 0; k < 60 && !seen_done; k++) begin
      ready = (k % 3 == 0);
      if (k == 2) data = 8'hFF;
      #1;
      if (done[0]) seen_done = 1'b1;
      else begin
        chk("bp_valid", vld[0], 1'b1);
        chk("bp_sdo", sdo[0], q[b]);
        chk("bp_last", last[0], (b == 8));
        if (ready) begin hs++; b++; end
      end
      cyc();
    end
    chk("bp_done_seen", seen_done, 1'b1);
    chk("bp_handshakes", hs, 9);

    // Enable gap after three beats; then DONE entered and frozen by E_i=0.
    do_reset();
    q = 9'h00F;
    data = 8'h0F; start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        e = 1'b0;
        for (int g = 0; g < 5; g++) begin
          #1;
          chk("egap_valid", vld[0], 1'b0);
          chk("egap_last", last[0], 1'b0);
          cyc();
        end
        e = 1'b1;
        #1;
      end
      chk("egap_sdo", sdo[0], q[i]);
      chk("egap_vld", vld[0], 1'b1);
      cyc();
    end
    e = 1'b0;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("edone_hold", done[0], 1'b1);
      chk("edone_busy", busy[0], 1'b1);
      chk("edone_valid", vld[0], 1'b0);
      cyc();
    end
    e = 1'b1;
    #1;
    chk("edone_release", done[0], 1'b1);
    cyc();
    chk("edone_cleared", done[0], 1'b0);

    // Reset (with E_i low) while beat 5 is on the wire aborts the frame.
    do_reset();
    q = 9'h0A5;
    data = 8'hA5; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("rst_pre_sdo", sdo[0], q[4]);
    reset = 1'b1; e = 1'b0;
    cyc();
    reset = 1'b0; e = 1'b1;
    #1;
    chk("rst_outputs", {27'd0, sdo[0], vld[0], last[0], busy[0], done[0]}, 32'd0);
    for (int g = 0; g < 3; g++) begin
      cyc();
      chk("rst_no_done", {done[0], busy[0]}, 2'b00);
    end
    run_frame(0, 8'hA5, 9'h0A5, 9, "rst_clean");

    // start_i held high, no parity: frames repeat with a fixed 3-cycle cadence.
    do_reset();
    data = 8'hC3; start = 1'b1;
    b = 0; fr = 0; last_hs = -1; prev_v = 1'b0;
    for (int k = 0; k < 80 && fr < 3; k++) begin
      cyc();
      q = (fr == 0) ? 9'h0C3 : 9'h05A;
      if (vld[2]) begin
        if (b == 0 && last_hs >= 0) chk("cont_gap", k - last_hs, 3);
        chk("cont_sdo", sdo[2], q[b]);
        chk("cont_last", last[2], (b == 7));
        if (fr == 0 && b == 1) data = 8'h5A;
        if (b == 7) begin last_hs = k; b = 0; fr++; end
        else b++;
      end
      prev_v = vld[2];
    end
    start = 1'b0;
    chk("cont_frames", fr, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
